// File: rtl/gs_dac_pkg.sv
// Shared defaults and channel-index helpers for the GS DAC mixer.
// Pure constants: no latency, no backpressure.
package gs_dac_pkg;
    localparam int GS_NCH      = 4;
    localparam int GS_SW       = 8;
    localparam int GS_VW       = 6;
    localparam int GS_VOL_STEP = 31;
    localparam int CH_W        = 3;

    function automatic logic ch_ok(input logic [CH_W-1:0] ch, input int nch);
        return int'(ch) < nch;
    endfunction
endpackage

// File: rtl/gs_sd_chan.sv
// One first-order sigma-delta channel; dac is the registered accumulator carry.
// Latency 1 clock from en/smp to dac; no backpressure (free-running).
module gs_sd_chan #(
    parameter int SW = 8
) (
    input  logic          clk32,
    input  logic          rst,
    input  logic          en,
    input  logic [SW-1:0] smp,
    output logic          dac
);
    logic [SW:0] acc_q, acc_d;

    // A disabled cycle kills the pending carry but keeps the residue.
    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = {1'b0, acc_q[SW-1:0]} + {1'b0, smp};
        end else begin
            acc_d[SW] = 1'b0;
        end
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign dac = acc_q[SW];
endmodule

// File: rtl/gs_dac_mixer.sv
// NCH-channel GS DAC mixer: volume PWM gating per-channel sigma-delta modulators.
// Write-to-dac latency 2 clocks; no backpressure. GS_DAC_SHADOW_EN adds commit-aligned sample shadows.
module gs_dac_mixer
    import gs_dac_pkg::*;
#(
    parameter int NCH      = GS_NCH,
    parameter int SW       = GS_SW,
    parameter int VW       = GS_VW,
    parameter int VOL_STEP = GS_VOL_STEP
) (
    input  logic            clk32,
    input  logic            rst,
    input  logic            smp_we,
    input  logic [CH_W-1:0] smp_ch,
    input  logic [SW-1:0]   smp_d,
    input  logic            vol_we,
    input  logic [CH_W-1:0] vol_ch,
    input  logic [VW-1:0]   vol_d,
    input  logic            commit,
    input  logic [CH_W-1:0] rd_ch,
    output logic [VW-1:0]   rd_vol,
    output logic [NCH-1:0]  dac
);
    localparam logic [VW-1:0] STEP = VOL_STEP[VW-1:0];

    logic [VW-1:0]  vlm_q [NCH];
    logic [VW-1:0]  vlm_d [NCH];
    logic [SW-1:0]  act_q [NCH];
    logic [SW-1:0]  act_d [NCH];
    logic [VW-1:0]  vol_cnt_q, vol_cnt_d;
    logic [NCH-1:0] vol_en_q, vol_en_d;
    logic           smp_ok, vol_ok;

    assign smp_ok = smp_we && ch_ok(smp_ch, NCH);
    assign vol_ok = vol_we && ch_ok(vol_ch, NCH);

`ifdef GS_DAC_SHADOW_EN
    logic [SW-1:0] shd_q [NCH];
    logic [SW-1:0] shd_d [NCH];
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

    always_comb begin
        vol_cnt_d = vol_cnt_q + STEP;
        for (int i = 0; i < NCH; i++) begin
            vlm_d[i]    = vlm_q[i];
            act_d[i]    = act_q[i];
            vol_en_d[i] = vol_cnt_q < vlm_q[i];
            if (vol_ok && vol_ch == CH_W'(i)) begin
                vlm_d[i] = vol_d;
            end
`ifdef GS_DAC_SHADOW_EN
            // Commit copies the pre-edge shadow, so a colliding write waits for the next commit.
            shd_d[i] = shd_q[i];
            if (commit) begin
                act_d[i] = shd_q[i];
            end
            if (smp_ok && smp_ch == CH_W'(i)) begin
                shd_d[i] = smp_d;
            end
`else
            if (smp_ok && smp_ch == CH_W'(i)) begin
                act_d[i] = smp_d;
            end
`endif
        end
    end

    always_ff @(posedge clk32 or posedge rst) begin
        if (rst) begin
            vlm_q     <= '{default: '0};
            act_q     <= '{default: '0};
            vol_cnt_q <= '0;
            vol_en_q  <= '0;
`ifdef GS_DAC_SHADOW_EN
            shd_q     <= '{default: '0};
`endif
        end else begin
            vlm_q     <= vlm_d;
            act_q     <= act_d;
            vol_cnt_q <= vol_cnt_d;
            vol_en_q  <= vol_en_d;
`ifdef GS_DAC_SHADOW_EN
            shd_q     <= shd_d;
`endif
        end
    end

    always_comb begin
        rd_vol = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_vol = vlm_q[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        gs_sd_chan #(
            .SW(SW)
        ) u_chan (
            .clk32(clk32),
            .rst  (rst),
            .en   (vol_en_q[g]),
            .smp  (act_q[g]),
            .dac  (dac[g])
        );
    end
endmodule
